// File: rtl/cos_sine_seq_ctrl_if.sv
// Sample bus from the sine/cosine sequencer to the quadrant-reconstruction stage.
// Carries the quadrant and both magnitudes with a valid/ready handshake.
interface cos_sine_seq_ctrl_if;
    logic [1:0]  oQuad;
    logic [15:0] oY_g_a;
    logic [15:0] oY_g_b;
    logic        oValid;
    logic        iReady;

    modport master (
        output oQuad,
        output oY_g_a,
        output oY_g_b,
        output oValid,
        input  iReady
    );

    modport slave (
        input  oQuad,
        input  oY_g_a,
        input  oY_g_b,
        input  oValid,
        output iReady
    );
endinterface

// File: rtl/cos_sine_seq_ctrl.sv
// Phase accumulator + quarter-wave LUT read sequencer (sin at k, cos at 2^ADDR_W-k); PHASE_OFFSET_EN adds iPhaseOffs.
// Latency: oValid 3+LUT_LAT cycles after the latch cycle, constant for every k.
// Backpressure: OUT holds the sample, accumulator and LUT idle until iReady; one sample in flight at a time.
module cos_sine_seq_ctrl #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int LUT_LAT = 1
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iEn,
    input  logic [PHASE_W-1:0] iFreq,
`ifdef PHASE_OFFSET_EN
    input  logic [PHASE_W-1:0] iPhaseOffs,
`endif
    output logic               oLutEn,
    output logic [ADDR_W-1:0]  oLutAddr,
    input  logic [15:0]        iLutData,
    cos_sine_seq_ctrl_if.master smp,
    output logic               oBusy
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WAIT,
        OUT
    } state_t;

    state_t             state;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_sel;
    logic [ADDR_W+1:0]  sel_top;
    logic [ADDR_W-1:0]  k_q;
    logic [2:0]         wait_cnt;
    logic               lut_tag;
    logic [LUT_LAT-1:0] pipe_en;
    logic [LUT_LAT-1:0] pipe_tag;
    logic [1:0]         quad_q;
    logic [15:0]        y_a_q;
    logic [15:0]        y_b_q;
    logic               valid_q;
    logic               latch;

`ifdef PHASE_OFFSET_EN
    assign phase_sel = phase + iPhaseOffs;
`else
    assign phase_sel = phase;
`endif

    // Top ADDR_W+2 bits: quadrant in the upper two, in-quadrant index below.
    assign sel_top = (ADDR_W+2)'(phase_sel >> (PHASE_W - ADDR_W - 2));

    assign latch = iEn && ((state == IDLE) ||
                           (state == OUT && valid_q && smp.iReady));

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state    <= IDLE;
            phase    <= '0;
            k_q      <= '0;
            wait_cnt <= '0;
            lut_tag  <= 1'b0;
            pipe_en  <= '0;
            pipe_tag <= '0;
            quad_q   <= '0;
            y_a_q    <= '0;
            y_b_q    <= '0;
            valid_q  <= 1'b0;
            oLutEn   <= 1'b0;
            oLutAddr <= '0;
            oBusy    <= 1'b0;
        end else begin
            // Tag pipeline tracks each strobe so only genuine returns are captured.
            pipe_en[0]  <= oLutEn;
            pipe_tag[0] <= lut_tag;
            for (int i = 1; i < LUT_LAT; i++) begin
                pipe_en[i]  <= pipe_en[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
            if (pipe_en[LUT_LAT-1]) begin
                if (pipe_tag[LUT_LAT-1])
                    y_b_q <= iLutData;
                else
                    y_a_q <= iLutData;
            end

            if (latch) begin
                phase    <= phase + iFreq;
                quad_q   <= sel_top[ADDR_W+1 -: 2];
                k_q      <= sel_top[ADDR_W-1:0];
                oLutEn   <= 1'b1;
                oLutAddr <= sel_top[ADDR_W-1:0];
                lut_tag  <= 1'b0;
                valid_q  <= 1'b0;
                oBusy    <= 1'b1;
                state    <= RD_A;
            end else begin
                case (state)
                    IDLE: begin
                        oBusy <= 1'b0;
                    end
                    RD_A: begin
                        // cos index 2^ADDR_W-k is out of table range for k=0; skip the read.
                        oLutEn   <= (k_q != '0);
                        oLutAddr <= -k_q;
                        lut_tag  <= 1'b1;
                        state    <= RD_B;
                    end
                    RD_B: begin
                        oLutEn   <= 1'b0;
                        wait_cnt <= '0;
                        if (k_q == '0)
                            y_b_q <= 16'hFFFF;
                        state    <= WAIT;
                    end
                    WAIT: begin
                        if (wait_cnt == 3'(LUT_LAT - 1)) begin
                            valid_q <= 1'b1;
                            state   <= OUT;
                        end else begin
                            wait_cnt <= wait_cnt + 3'd1;
                        end
                    end
                    OUT: begin
                        if (valid_q && smp.iReady) begin
                            valid_q <= 1'b0;
                            oBusy   <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign smp.oQuad  = quad_q;
    assign smp.oY_g_a = y_a_q;
    assign smp.oY_g_b = y_b_q;
    assign smp.oValid = valid_q;

endmodule
